incident_event_queue: RTL and testbench

Upstream feeder for the UART top level. Watches the two ADS alarm overview flag vectors and turns every change into a 4-byte incident record, with the current RTC second as a timestamp. Records are buffered in a small FIFO. They are presented one at a time on incident_inform / incident_b0..b3, with a guaranteed hold-off between records so the UART control logic can finish transmitting each incident frame.

---
 rtl/incident_event_queue.sv | 171 +++++++++++++++++
 tb/tb_incident_event_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/incident_event_queue.sv
//==============================================================================
// Module   : incident_event_queue
// Purpose  : Turns ADS alarm-flag changes into timestamped 4-byte incident
//            records, buffers them in a FIFO and emits them one at a time
//            with a guaranteed idle gap between records.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module incident_event_queue #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [7:0]               ALARM_Overview_Tflag_ads1,
   input  logic [7:0]               ALARM_Overview_Tflag_ads2,
   input  logic [7:0]               second,
   output logic                     incident_inform,
   output logic [7:0]               incident_b0,
   output logic [7:0]               incident_b1,
   output logic [7:0]               incident_b2,
   output logic [7:0]               incident_b3,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     queue_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

   logic [7:0]  f1_q, f2_q, sec_q;
   logic [7:0]  ref1, ref2;
   logic [31:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_cur, level_nxt;
   logic        full_cur, empty_cur;
   logic        push1, push2, push, pop;
   logic [31:0] push_rec;
   state_t      state, state_nxt;
   logic [CW-1:0] gap_cnt, gap_nxt;

   // Occupancy and full/empty decoded from the committed pointers
   always_comb begin
      level_cur = wr_ptr - rd_ptr;
      full_cur  = (level_cur == FULL_LVL);
      empty_cur = (wr_ptr == rd_ptr);
   end

   // Capture decision: ads1 has fixed priority, at most one push per cycle
   always_comb begin
      push1    = en && !full_cur && (f1_q != ref1);
      push2    = en && !full_cur && !push1 && (f2_q != ref2);
      push     = push1 || push2;
      push_rec = push1 ? {8'h01, f1_q, f1_q ^ ref1, sec_q}
                       : {8'h02, f2_q, f2_q ^ ref2, sec_q};
   end

   // Emit FSM: the strobe cycle itself is not counted, so the gap counter
   // spans GAP_CYCLES idle cycles and strobes land GAP_CYCLES+1 apart
   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_cur) begin
               pop       = 1'b1;
               gap_nxt   = GAP_LOAD;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (incident_inform) begin
               gap_nxt = gap_cnt;
            end else if (gap_cnt != '0) begin
               gap_nxt = gap_cnt - CW'(1);
            end else if (!empty_cur) begin
               pop     = 1'b1;
               gap_nxt = GAP_LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next pointer values, used for the registered level/full outputs
   always_comb begin
      wr_ptr_nxt = wr_ptr + (AW + 1)'(push);
      rd_ptr_nxt = rd_ptr + (AW + 1)'(pop);
      level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Input stage: register flags and timestamp once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f1_q  <= 8'h00;
         f2_q  <= 8'h00;
         sec_q <= 8'h00;
      end else begin
         f1_q  <= ALARM_Overview_Tflag_ads1;
         f2_q  <= ALARM_Overview_Tflag_ads2;
         sec_q <= second;
      end
   end

   // Last-reported references; tracked silently while capture is disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref1 <= 8'h00;
         ref2 <= 8'h00;
      end else if (!en) begin
         ref1 <= f1_q;
         ref2 <= f2_q;
      end else if (push1) begin
         ref1 <= f1_q;
      end else if (push2) begin
         ref2 <= f2_q;
      end
   end

   // Record storage (no reset needed: only committed entries are read)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_rec;
      end
   end

   // Pointers, registered occupancy and FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         queue_full <= 1'b0;
         state      <= IDLE;
         gap_cnt    <= '0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         fifo_level <= level_nxt;
         queue_full <= (level_nxt == FULL_LVL);
         state      <= state_nxt;
         gap_cnt    <= gap_nxt;
      end
   end

   // Output record: strobe for one cycle, bytes hold until the next pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         incident_inform <= 1'b0;
         incident_b0     <= 8'h00;
         incident_b1     <= 8'h00;
         incident_b2     <= 8'h00;
         incident_b3     <= 8'h00;
      end else begin
         incident_inform <= pop;
         if (pop) begin
            {incident_b0, incident_b1, incident_b2, incident_b3} <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_incident_event_queue.sv
//==============================================================================
// Module   : tb_incident_event_queue
// Purpose  : Self-checking bench for incident_event_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_incident_event_queue;

   localparam int DEPTH = 8;
   localparam int GAP   = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] a1, a2, sec;
   logic       incident_inform;
   logic [7:0] incident_b0, incident_b1, incident_b2, incident_b3;
   logic [3:0] fifo_level;
   logic       queue_full;

   always #5 clk = ~clk;

   incident_event_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .en                        (en),
      .ALARM_Overview_Tflag_ads1 (a1),
      .ALARM_Overview_Tflag_ads2 (a2),
      .second                    (sec),
      .incident_inform           (incident_inform),
      .incident_b0               (incident_b0),
      .incident_b1               (incident_b1),
      .incident_b2               (incident_b2),
      .incident_b3               (incident_b3),
      .fifo_level                (fifo_level),
      .queue_full                (queue_full)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: records in a queue, refs per source, and the earliest
   // cycle at which another record may be emitted
   logic [31:0] mq[$];
   logic [7:0]  m_f1, m_f2, m_sec, m_ref1, m_ref2;
   logic        m_inform;
   logic [31:0] m_rec;
   longint      cyc, m_next;
   int          dut_pulses, m_pulses;
   bit          saw_full;

   task automatic model_reset();
      mq.delete();
      m_f1 = 0; m_f2 = 0; m_sec = 0; m_ref1 = 0; m_ref2 = 0;
      m_inform = 0; m_rec = 0; m_next = 0;
   endtask

   task automatic model_step();
      bit was_full;
      cyc++;
      if (!reset) begin
         model_reset();
         return;
      end
      was_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && cyc >= m_next) begin
         m_rec    = mq.pop_front();
         m_inform = 1;
         m_next   = cyc + GAP + 1;
         m_pulses++;
      end else begin
         m_inform = 0;
      end
      if (!en) begin
         m_ref1 = m_f1;
         m_ref2 = m_f2;
      end else if (!was_full) begin
         if (m_f1 != m_ref1) begin
            mq.push_back({8'h01, m_f1, m_f1 ^ m_ref1, m_sec});
            m_ref1 = m_f1;
         end else if (m_f2 != m_ref2) begin
            mq.push_back({8'h02, m_f2, m_f2 ^ m_ref2, m_sec});
            m_ref2 = m_f2;
         end
      end
      m_f1 = a1; m_f2 = a2; m_sec = sec;
   endtask

   task automatic compare();
      if (incident_inform) dut_pulses++;
      if (queue_full) saw_full = 1;
      check("inform", 32'(incident_inform), 32'(m_inform));
      check("record", {incident_b0, incident_b1, incident_b2, incident_b3}, m_rec);
      check("level", 32'(fifo_level), mq.size());
      check("full", 32'(queue_full), 32'(mq.size() == DEPTH));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pulse(input int maxc, output int n);
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (incident_inform) begin
            n = i;
            break;
         end
      end
   endtask

   int n, p0;
   logic [7:0] s3_vals [10];

   initial begin
      s3_vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h11, 8'h12};
      cyc = 0; dut_pulses = 0; m_pulses = 0; saw_full = 0;
      model_reset();
      reset = 1'b0; en = 1'b1; a1 = 8'h00; a2 = 8'h00; sec = 8'h00;
      #1;
      check("rst_outputs", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h0);
      check("rst_level", 32'(fifo_level), 32'h0);
      ticks(3);
      @(negedge clk);
      reset = 1'b1;

      // Scenario 1: quiet inputs, then a single ads1 change
      p0 = dut_pulses;
      ticks(50);
      check("s1_quiet_pulses", dut_pulses - p0, 0);
      a1 = 8'h05; sec = 8'h42;
      wait_pulse(10, n);
      check("s1_latency", n, 3);
      check("s1_rec", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h01050542);
      ticks(40);

      // Scenario 2: simultaneous changes, ads1 first then ads2
      a1 = 8'h00; ticks(40);
      a1 = 8'h01; a2 = 8'h80; sec = 8'h07;
      wait_pulse(10, n);
      check("s2_first", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h01010107);
      wait_pulse(40, n);
      check("s2_spacing", n, GAP + 1);
      check("s2_second", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h02808007);
      ticks(40);

      // Scenario 3: rapid ads1 changes fill the FIFO
      a1 = 8'h00; ticks(60);
      saw_full = 0; p0 = dut_pulses;
      foreach (s3_vals[i]) begin
         a1 = s3_vals[i]; sec = 8'(8'h20 + i);
         ticks(2);
      end
      ticks(12 * (GAP + 1));
      check("s3_saw_full", 32'(saw_full), 32'h1);
      check("s3_level_drained", 32'(fifo_level), 32'h0);
      check("s3_last_b1", 32'(incident_b1), 32'h12);
      check("s3_last_mask", 32'(incident_b2), 32'(8'h12 ^ 8'h11));

      // Scenario 4: asynchronous reset in the middle of a gap
      for (int i = 0; i < 5; i++) begin
         a1 = 8'(8'h30 + i); ticks(2);
      end
      ticks(3);
      a1 = 8'h00; a2 = 8'h03; sec = 8'h55;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("s4_rst_inform", 32'(incident_inform), 32'h0);
      check("s4_rst_rec", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h0);
      check("s4_rst_level", 32'(fifo_level), 32'h0);
      ticks(2);
      @(negedge clk);
      reset = 1'b1;
      p0 = dut_pulses;
      ticks(60);
      check("s4_pulses", dut_pulses - p0, 1);
      check("s4_rec", {incident_b0, incident_b1, incident_b2, incident_b3}, 32'h02030355);

      // Scenario 5: changes while disabled are absorbed silently
      p0 = dut_pulses;
      en = 1'b0; a1 = 8'hFF; ticks(3);
      a1 = 8'h0F; ticks(3);
      en = 1'b1; ticks(40);
      check("s5_no_pulses", dut_pulses - p0, 0);
      a1 = 8'h0E;
      wait_pulse(10, n);
      check("s5_latency", n, 3);
      check("s5_rec_b1", 32'(incident_b1), 32'h0E);
      check("s5_rec_mask", 32'(incident_b2), 32'h01);
      ticks(40);

      // Random phase with varying change rates
      for (int seg = 0; seg < 4; seg++) begin
         int rate;
         rate = (seg == 2) ? 70 : 8 + seg * 5;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < rate) a1 = 8'($urandom);
            if ($urandom_range(0, 99) < rate) a2 = 8'($urandom);
            if ($urandom_range(0, 99) < 30)   sec = 8'($urandom);
            if ($urandom_range(0, 99) < 2)    en = ~en;
            tick();
         end
      end
      en = 1'b1;
      ticks((DEPTH + 2) * (GAP + 1));
      check("total_pulses", dut_pulses, m_pulses);
      check("final_level", 32'(fifo_level), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
